// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 host-to-device transmitter.
`timescale 1ns/1ps
package ps2_pkg;

  // Transmit sequencer states.
  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SHIFT,
    ACK,
    RELEASE,
    DONE
  } tx_state_t;

  // Start + 8 data + parity + stop.
  localparam int PS2_FRAME_BITS = 11;

  // Odd parity bit: makes the total count of ones across data+parity odd.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 line conditioning: 2-flop synchronisers on clock and data, a
// FILTER_LEN-sample glitch filter on the clock and a falling-edge pulse.
`timescale 1ns/1ps
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic clk_filt,
  output logic data_sync,
  output logic fall
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam logic [FW-1:0] CNT_LAST = FW'(FILTER_LEN - 1);

  logic          clk_meta_q, clk_sync_q;
  logic          data_meta_q, data_sync_q;
  logic          filt_q, filt_d;
  logic [FW-1:0] cnt_q, cnt_d;
  logic          fall_q, fall_d;

  // Filter: accept a new clock level only after FILTER_LEN consecutive samples.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (clk_sync_q != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = clk_sync_q;
      end else begin
        cnt_d = cnt_q + FW'(1);
      end
    end
    fall_d = filt_q & ~filt_d;
  end

  // Synchronisers and filter state; lines idle high, so reset to 1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
      filt_q      <= 1'b1;
      cnt_q       <= '0;
      fall_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the
      // pre-edge value of its neighbour, which is what makes the chain a
      // synchroniser instead of a single wire.
      clk_meta_q  <= ps2_clk_i;
      clk_sync_q  <= clk_meta_q;
      data_meta_q <= ps2_data_i;
      data_sync_q <= data_meta_q;
      filt_q      <= filt_d;
      cnt_q       <= cnt_d;
      fall_q      <= fall_d;
    end
  end

  assign clk_filt  = filt_q;
  assign data_sync = data_sync_q;
  assign fall      = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, bit shift
// on device clock falls, ACK check, line release and result reporting.
`timescale 1ns/1ps
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       done,
  output logic       ack_err,
  output logic       timeout_err,
  output logic       rx_inhibit,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int MAX_CYCLES = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam int SHIFT_W    = PS2_FRAME_BITS - 1;
  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       LAST_BIT     = 4'(SHIFT_W - 1);

  logic clk_filt, data_sync, fall;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk_i  (ps2_clk_i),
    .ps2_data_i (ps2_data_i),
    .clk_filt   (clk_filt),
    .data_sync  (data_sync),
    .fall       (fall)
  );

  tx_state_t          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         bit_cnt_q, bit_cnt_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic               clk_oe_q, clk_oe_d;
  logic               data_oe_q, data_oe_d;
  logic               ack_bad_q, ack_bad_d;
  logic               done_q, done_d;
  logic               ack_err_q, ack_err_d;
  logic               timeout_err_q, timeout_err_d;

  logic in_frame, timeout;
  assign in_frame = (state_q == REQ) || (state_q == SHIFT) ||
                    (state_q == ACK) || (state_q == RELEASE);
  assign timeout  = in_frame && (cnt_q == TIMEOUT_LAST);

  // Next-state, counters and registered line/result outputs.
  always_comb begin
    // NOTE: every signal written here gets a default first so that no path
    // leaves it unassigned and no latch is inferred.
    state_d       = state_q;
    cnt_d         = cnt_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    clk_oe_d      = 1'b0;
    data_oe_d     = data_oe_q;
    ack_bad_d     = ack_bad_q;
    done_d        = 1'b0;
    ack_err_d     = 1'b0;
    timeout_err_d = 1'b0;

    if (in_frame) cnt_d = cnt_q + CNT_W'(1);

    case (state_q)
      IDLE: begin
        data_oe_d = 1'b0;
        ack_bad_d = 1'b0;
        if (tx_valid) begin
          state_d  = INHIBIT;
          clk_oe_d = 1'b1;
          cnt_d    = '0;
          shift_d  = {1'b1, odd_parity(tx_data), tx_data};
        end
      end
      INHIBIT: begin
        if (cnt_q == INHIBIT_LAST) begin
          state_d   = REQ;
          cnt_d     = '0;
          data_oe_d = 1'b1;                 // start bit, clock released
        end else begin
          cnt_d    = cnt_q + CNT_W'(1);
          clk_oe_d = 1'b1;
        end
      end
      REQ: begin
        bit_cnt_d = '0;
        state_d   = SHIFT;
      end
      SHIFT: begin
        if (fall) begin
          data_oe_d = ~shift_q[bit_cnt_q];
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == LAST_BIT) state_d = ACK;
        end
      end
      ACK: begin
        if (fall) begin
          ack_bad_d = data_sync;            // device must hold data low
          state_d   = RELEASE;
        end
      end
      RELEASE: begin
        if (clk_filt && data_sync) begin
          state_d   = DONE;
          done_d    = 1'b1;
          ack_err_d = ack_bad_q;
        end
      end
      DONE: begin
        state_d   = IDLE;
        data_oe_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    // Timeout wins over anything else happening in the same cycle.
    if (timeout) begin
      state_d       = DONE;
      clk_oe_d      = 1'b0;
      data_oe_d     = 1'b0;
      done_d        = 1'b1;
      ack_err_d     = 1'b0;
      timeout_err_d = 1'b1;
    end
  end

  // State and datapath registers; reset releases both lines at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      clk_oe_q      <= 1'b0;
      data_oe_q     <= 1'b0;
      ack_bad_q     <= 1'b0;
      done_q        <= 1'b0;
      ack_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      clk_oe_q      <= clk_oe_d;
      data_oe_q     <= data_oe_d;
      ack_bad_q     <= ack_bad_d;
      done_q        <= done_d;
      ack_err_q     <= ack_err_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign tx_ready    = (state_q == IDLE);
  assign rx_inhibit  = (state_q != IDLE);
  assign done        = done_q;
  assign ack_err     = ack_err_q;
  assign timeout_err = timeout_err_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a PS/2 device model and scoreboard.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int INH = 20;
  localparam int TO  = 3000;
  localparam int FL  = 2;

  typedef struct packed {
    logic ack_err;
    logic timeout_err;
  } res_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, done, ack_err, timeout_err, rx_inhibit;
  logic       ps2_clk_i, ps2_data_i, ps2_clk_oe, ps2_data_oe;
  logic       dev_clk_low, dev_data_low;

  // Open-collector bus: either side may pull low.
  assign ps2_clk_i  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_i = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TO),
    .FILTER_LEN     (FL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .done        (done),
    .ack_err     (ack_err),
    .timeout_err (timeout_err),
    .rx_inhibit  (rx_inhibit),
    .ps2_clk_i   (ps2_clk_i),
    .ps2_data_i  (ps2_data_i),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  always #5 clk = ~clk;

  int   n_assert = 0;
  int   n_fail   = 0;
  int   n_done   = 0;
  int   n_accept = 0;
  int   ready_viol = 0;
  logic busy_mon = 1'b0;

  logic [9:0] exp_frame_q[$];
  res_t       exp_res_q[$];

  always @(negedge clk) if (done === 1'b1) n_done++;
  always @(negedge clk) if (busy_mon && tx_ready !== 1'b0) ready_viol++;
  always @(posedge clk) if (reset && tx_valid && tx_ready) n_accept++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_parity(input logic [7:0] d);
    return ($countones(d) % 2) == 0;
  endfunction

  // Present a byte, push expectations, and measure the inhibit window.
  task automatic send(input logic [7:0] d, input bit hold, input bit push_res,
                      input logic exp_ack, input logic exp_to);
    int   n;
    res_t r;
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    exp_frame_q.push_back({1'b1, model_parity(d), d});
    if (push_res) begin
      r.ack_err     = exp_ack;
      r.timeout_err = exp_to;
      exp_res_q.push_back(r);
    end
    @(negedge clk);
    if (!hold) tx_valid = 1'b0;
    busy_mon = 1'b1;
    n = 0;
    while (ps2_clk_oe === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("inhibit_len", n, INH);
    check("start_bit_oe", ps2_data_oe, 1);
  endtask

  // Device clocks n_bits and samples data on each rising edge.
  task automatic device_bits(input int n_bits, input int glitch_bit, output logic [9:0] cap);
    cap = '0;
    for (int i = 0; i < n_bits; i++) begin
      repeat (10) @(negedge clk);
      dev_clk_low = 1'b1;
      repeat (20) @(negedge clk);
      dev_clk_low = 1'b0;
      cap[i] = ps2_data_i;
      if (i == glitch_bit) begin
        repeat (4) @(negedge clk);
        dev_clk_low = 1'b1;
        @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (5) @(negedge clk);
      end else begin
        repeat (10) @(negedge clk);
      end
    end
  endtask

  task automatic device_ack(input bit do_ack);
    if (do_ack) dev_data_low = 1'b1;
    repeat (10) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (20) @(negedge clk);
    dev_clk_low = 1'b0;
    repeat (5) @(negedge clk);
    dev_data_low = 1'b0;
  endtask

  task automatic check_frame(input logic [9:0] cap);
    check("sb_frame_avail", exp_frame_q.size() > 0, 1);
    if (exp_frame_q.size() > 0) check("frame_bits", cap, exp_frame_q.pop_front());
  endtask

  task automatic wait_done(input int bound, output int n);
    n = 0;
    while (done !== 1'b1 && n < bound) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic check_done();
    res_t r;
    check("done_seen", done, 1);
    check("sb_res_avail", exp_res_q.size() > 0, 1);
    if (exp_res_q.size() > 0) begin
      r = exp_res_q.pop_front();
      check("ack_err", ack_err, r.ack_err);
      check("timeout_err", timeout_err, r.timeout_err);
    end
    check("clk_oe_at_done", ps2_clk_oe, 0);
    check("data_oe_at_done", ps2_data_oe, 0);
    tx_valid = 1'b0;
    busy_mon = 1'b0;
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("ack_err_cleared", ack_err, 0);
    check("timeout_err_cleared", timeout_err, 0);
    check("ready_after_done", tx_ready, 1);
  endtask

  task automatic full_frame(input logic [7:0] d, input bit hold, input int glitch_bit);
    logic [9:0] cap;
    int n;
    send(d, hold, 1'b1, 1'b0, 1'b0);
    device_bits(10, glitch_bit, cap);
    check_frame(cap);
    device_ack(1'b1);
    wait_done(300, n);
    check_done();
  endtask

  initial begin
    logic [9:0] cap;
    int n, done0, acc0;

    reset = 1'b1; tx_valid = 1'b0; tx_data = '0;
    dev_clk_low = 1'b0; dev_data_low = 1'b0;
    #3 reset = 1'b0;
    #4;
    check("rst_tx_ready", tx_ready, 1);
    check("rst_done", done, 0);
    check("rst_errs", {ack_err, timeout_err}, 0);
    check("rst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
    check("rst_rx_inhibit", rx_inhibit, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Device clock activity while idle must be ignored.
    done0 = n_done;
    dev_clk_low = 1'b1;
    repeat (20) @(negedge clk);
    dev_clk_low = 1'b0;
    repeat (10) @(negedge clk);
    check("idle_fall_ready", tx_ready, 1);
    check("idle_fall_oe", {ps2_clk_oe, ps2_data_oe}, 0);
    check("idle_fall_no_done", n_done, done0);

    // Set-LEDs command with ACK.
    full_frame(8'hED, 1'b0, -1);

    // All-zero byte: parity must be 1.
    send(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    device_bits(10, -1, cap);
    check("zero_data", cap[7:0], 8'h00);
    check("zero_parity", cap[8], 1);
    check_frame(cap);
    device_ack(1'b1);
    wait_done(300, n);
    check_done();

    // Device omits ACK.
    send(8'hA5, 1'b0, 1'b1, 1'b1, 1'b0);
    device_bits(10, -1, cap);
    check_frame(cap);
    device_ack(1'b0);
    wait_done(300, n);
    check_done();

    // Device never clocks: timeout after TO cycles from clock release.
    send(8'h3C, 1'b0, 1'b1, 1'b0, 1'b1);
    exp_frame_q.delete();
    wait_done(4000, n);
    check("timeout_cycles", n, TO);
    check_done();

    // Reset in the middle of SHIFT, then a clean frame.
    send(8'h40, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_frame_q.delete();
    device_bits(4, -1, cap);
    check("mid_shift_data_oe", ps2_data_oe, 1);
    done0 = n_done;
    #2 reset = 1'b0;
    #1;
    check("mid_rst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
    check("mid_rst_ready", tx_ready, 1);
    check("mid_rst_rx_inhibit", rx_inhibit, 0);
    busy_mon = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (30) @(negedge clk);
    check("mid_rst_no_done", n_done, done0);
    full_frame(8'hFF, 1'b0, -1);

    // Glitch on the device clock during SHIFT must not shift an extra bit.
    full_frame(8'hF4, 1'b0, 3);

    // tx_valid held high for the whole frame: one accept only.
    acc0 = n_accept;
    full_frame(8'h5A, 1'b1, -1);
    repeat (5) @(negedge clk);
    check("hold_one_accept", n_accept - acc0, 1);
    check("ready_low_while_busy", ready_viol, 0);
    check("hold_idle_after", ps2_clk_oe, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
